ingress_fifo: RTL and testbench

INGRESS_FIFO -- requirements
Module: ingress_fifo

---
 rtl/ingress_fifo.sv | 89 ++++++++
 tb/tb_ingress_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ingress_fifo.sv
// Ingress FIFO with show-ahead head output, zeroed head when empty,
// accepted write-on-full when a read frees a slot, and a saturating drop counter.
module ingress_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     wrreq,
    output logic                     full,
    input  logic                     rdreq,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [UW-1:0] usedw_q, usedw_d;
    logic [7:0]    drop_q, drop_d;

    logic rd_ok;
    logic wr_ok;
    logic drop;

    assign empty    = (usedw_q == UW'(0));
    assign full     = (usedw_q == UW'(DEPTH));
    assign usedw    = usedw_q;
    assign drop_cnt = drop_q;

    // Idle head reads as zero so the scheduler sees destination 00.
    assign q = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_ok    = rdreq & ~empty;
        wr_ok    = wrreq & (~full | rd_ok);
        drop     = wrreq & ~wr_ok;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        usedw_d  = usedw_q;
        drop_d   = drop_q;

        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase

        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usedw_q  <= '0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            usedw_q  <= usedw_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; a full-plus-read write lands in the slot being freed.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_ingress_fifo.sv
// Bench for ingress_fifo: queue-based reference model checked every cycle
// plus directed sequences with literal expectations.
module tb_ingress_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       wrreq;
    logic       full;
    logic       rdreq;
    logic [7:0] q;
    logic       empty;
    logic [4:0] usedw;
    logic [7:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ingress_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .wrreq    (wrreq),
        .full     (full),
        .rdreq    (rdreq),
        .q        (q),
        .empty    (empty),
        .usedw    (usedw),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue capped at 16 by rule.
    logic [7:0] m_q [$];
    int         m_drop = 0;
    bit         armed  = 0;

    always @(posedge clk) begin
        bit rd_ok, wr_ok;
        if (reset) begin
            m_q.delete();
            m_drop = 0;
            armed  = 1;
        end else if (armed) begin
            rd_ok = rdreq && (m_q.size() > 0);
            wr_ok = wrreq && ((m_q.size() < 16) || rd_ok);
            if (rd_ok) void'(m_q.pop_front());
            if (wr_ok) m_q.push_back(data_in);
            else if (wrreq && m_drop < 255) m_drop++;
        end
        #1;
        if (armed) begin
            chk("m_usedw", int'(usedw), m_q.size());
            chk("m_empty", int'(empty), int'(m_q.size() == 0));
            chk("m_full", int'(full), int'(m_q.size() == 16));
            chk("m_q", int'(q), (m_q.size() > 0) ? int'(m_q[0]) : 0);
            chk("m_drop", int'(drop_cnt), m_drop);
        end
    end

    // Drive at a falling edge, then advance to the next falling edge.
    task automatic cyc(input bit r, input bit wr, input logic [7:0] d, input bit rd);
        reset   = r;
        wrreq   = wr;
        data_in = d;
        rdreq   = rd;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        cyc(1, 1, 8'h77, 1);
        cyc(1, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_usedw", int'(usedw), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        // Single write then read
        cyc(0, 1, 8'h05, 0);
        chk("w1_q", int'(q), 8'h05);
        chk("w1_empty", int'(empty), 0);
        chk("w1_usedw", int'(usedw), 1);
        cyc(0, 0, 8'h00, 1);
        chk("r1_empty", int'(empty), 1);
        chk("r1_q", int'(q), 0);
        chk("r1_usedw", int'(usedw), 0);

        // Fill, overflow by one, drain in order
        for (int i = 1; i <= 16; i++) cyc(0, 1, 8'(i), 0);
        cyc(0, 1, 8'hFF, 0);
        chk("ovf_full", int'(full), 1);
        chk("ovf_usedw", int'(usedw), 16);
        chk("ovf_drop", int'(drop_cnt), 1);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_q", int'(q), i);
            cyc(0, 0, 8'h00, 1);
        end
        chk("drain_empty", int'(empty), 1);

        // Full plus simultaneous read and write
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h21 + i), 0);
        cyc(0, 1, 8'hAA, 1);
        chk("rw_usedw", int'(usedw), 16);
        chk("rw_drop", int'(drop_cnt), 1);
        for (int i = 0; i < 15; i++) begin
            chk("rw_q", int'(q), 8'h22 + i);
            cyc(0, 0, 8'h00, 1);
        end
        chk("rw_last", int'(q), 8'hAA);
        cyc(0, 0, 8'h00, 1);
        chk("rw_empty", int'(empty), 1);

        // Read on empty is ignored
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 1);
            chk("idle_usedw", int'(usedw), 0);
            chk("idle_empty", int'(empty), 1);
        end
        cyc(0, 1, 8'h02, 0);
        chk("idle_wr_q", int'(q), 8'h02);
        cyc(0, 0, 8'h00, 1);
        chk("idle_rd_empty", int'(empty), 1);

        // Streaming: pointers wrap twice with occupancy one
        cyc(0, 1, 8'h40, 0);
        for (int i = 1; i < 40; i++) begin
            cyc(0, 1, 8'(8'h40 + i), 1);
            chk("stream_usedw", int'(usedw), 1);
            chk("stream_q", int'(q), 8'h40 + i);
        end
        cyc(0, 0, 8'h00, 1);
        chk("stream_empty", int'(empty), 1);

        // Drop counter saturation and mid-operation reset
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h80 + i), 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 8'hEE, 0);
        chk("sat_drop", int'(drop_cnt), 255);
        chk("sat_usedw", int'(usedw), 16);
        for (int i = 0; i < 7; i++) cyc(0, 0, 8'h00, 1);
        chk("pre_rst_usedw", int'(usedw), 9);
        chk("pre_rst_q", int'(q), 8'h87);
        cyc(1, 1, 8'h99, 1);
        cyc(0, 0, 8'h00, 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        chk("mid_rst_usedw", int'(usedw), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_q", int'(q), 0);
        cyc(0, 1, 8'h33, 0);
        chk("post_rst_q", int'(q), 8'h33);
        chk("post_rst_usedw", int'(usedw), 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
